// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline skid register family: reset constants,
// MIPS-style exception codes and the occupancy state encoding.
package pipe_pkg;

  localparam int                PIPE_EXC_W     = 5;
  localparam logic [31:0]       PIPE_INIT_PC   = 32'h0000_3000;
  localparam logic [31:0]       PIPE_INIT_DATA = 32'h0000_0000;

  localparam logic [PIPE_EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [PIPE_EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [PIPE_EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [PIPE_EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [PIPE_EXC_W-1:0] EXC_OV   = 5'd12;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Upstream and downstream valid/ready handshake of one pipeline stage boundary.
// The slave view belongs to the register; the master view belongs to its neighbours.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_instr;
  logic [EXC_W-1:0]  in_exc;
  logic              in_bd;

  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_instr;
  logic [EXC_W-1:0]  out_exc;
  logic              out_bd;

  modport master (
    output in_valid, in_pc, in_instr, in_exc, in_bd, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_exc, out_bd
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_exc, in_bd, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_exc, out_bd
  );
endinterface

// File: rtl/pipe_skid_reg_entry.sv
// One payload slot (pc, instr, exc, bd). Reset beats clear, clear beats load,
// otherwise the slot holds its value.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                PC_W      = 32,
  parameter int                EXC_W     = PIPE_EXC_W,
  parameter logic [PC_W-1:0]   INIT_PC   = PC_W'(PIPE_INIT_PC),
  parameter logic [DATA_W-1:0] INIT_DATA = DATA_W'(PIPE_INIT_DATA)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [PC_W-1:0]   clear_pc,
  input  logic              load,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [DATA_W-1:0] d_instr,
  input  logic [EXC_W-1:0]  d_exc,
  input  logic              d_bd,
  output logic [PC_W-1:0]   q_pc,
  output logic [DATA_W-1:0] q_instr,
  output logic [EXC_W-1:0]  q_exc,
  output logic              q_bd
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_pc    <= INIT_PC;
      q_instr <= INIT_DATA;
      q_exc   <= '0;
      q_bd    <= 1'b0;
    end else if (clear) begin
      q_pc    <= clear_pc;
      q_instr <= INIT_DATA;
      q_exc   <= '0;
      q_bd    <= 1'b0;
    end else if (load) begin
      q_pc    <= d_pc;
      q_instr <= d_instr;
      q_exc   <= d_exc;
      q_bd    <= d_bd;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with a two-entry skid: main drives the outputs,
// skid absorbs one extra entry so in_ready depends only on registered state.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                PC_W      = 32,
  parameter int                EXC_W     = PIPE_EXC_W,
  parameter logic [PC_W-1:0]   INIT_PC   = PC_W'(PIPE_INIT_PC),
  parameter logic [DATA_W-1:0] INIT_DATA = DATA_W'(PIPE_INIT_DATA)
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_skid_reg_if.slave        bus,
  input  logic                  flush,
  input  logic [PC_W-1:0]       flush_pc,
  output logic [1:0]            occupancy
);

  state_t            state;
  logic              in_xfer;
  logic              out_xfer;
  logic              main_load;
  logic              skid_load;
  logic              from_skid;

  logic [PC_W-1:0]   main_d_pc;
  logic [DATA_W-1:0] main_d_instr;
  logic [EXC_W-1:0]  main_d_exc;
  logic              main_d_bd;

  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_instr;
  logic [EXC_W-1:0]  skid_exc;
  logic              skid_bd;

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign occupancy     = state;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    from_skid = 1'b0;
    case (state)
      EMPTY: main_load = in_xfer;
      ONE: begin
        main_load = in_xfer & out_xfer;
        skid_load = in_xfer & ~out_xfer;
      end
      FULL: begin
        main_load = out_xfer;
        from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  // When FULL drains, the skid entry moves up so FIFO order is preserved.
  assign main_d_pc    = from_skid ? skid_pc    : bus.in_pc;
  assign main_d_instr = from_skid ? skid_instr : bus.in_instr;
  assign main_d_exc   = from_skid ? skid_exc   : bus.in_exc;
  assign main_d_bd    = from_skid ? skid_bd    : bus.in_bd;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_xfer) state <= ONE;
        ONE: begin
          if (in_xfer && !out_xfer)      state <= FULL;
          else if (out_xfer && !in_xfer) state <= EMPTY;
        end
        FULL:    if (out_xfer) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_entry #(
    .DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W),
    .INIT_PC(INIT_PC), .INIT_DATA(INIT_DATA)
  ) u_main (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .clear_pc (flush_pc),
    .load     (main_load),
    .d_pc     (main_d_pc),
    .d_instr  (main_d_instr),
    .d_exc    (main_d_exc),
    .d_bd     (main_d_bd),
    .q_pc     (bus.out_pc),
    .q_instr  (bus.out_instr),
    .q_exc    (bus.out_exc),
    .q_bd     (bus.out_bd)
  );

  pipe_entry #(
    .DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W),
    .INIT_PC(INIT_PC), .INIT_DATA(INIT_DATA)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .clear_pc (INIT_PC),
    .load     (skid_load),
    .d_pc     (bus.in_pc),
    .d_instr  (bus.in_instr),
    .d_exc    (bus.in_exc),
    .d_bd     (bus.in_bd),
    .q_pc     (skid_pc),
    .q_instr  (skid_instr),
    .q_exc    (skid_exc),
    .q_bd     (skid_bd)
  );

  // The skid slot may only be written while it is free.
  a_no_skid_overwrite: assert property (
    @(posedge clk) disable iff (reset) skid_load |-> (state != FULL)
  );

endmodule
